// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI period scheduler: encoder periods,
// scheduler states and the registered per-pixel output bundle.
package hdmi_pkg;

  typedef enum logic [1:0] {
    CTRL     = 2'd0,
    PREAMBLE = 2'd1,
    GUARD    = 2'd2,
    VIDEO    = 2'd3
  } enc_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;
  localparam int         PREAMBLE_LEN       = 8;
  localparam int         GUARD_LEN          = 2;

  localparam int HCOUNT_W = 12;
  localparam int VCOUNT_W = 11;

  typedef struct packed {
    logic      hsync;
    logic      vsync;
    logic      de;
    enc_mode_t mode;
    logic [3:0] ctl;
    logic      frame_start;
    logic      running;
  } pix_out_t;

  // Output bundle shown while idle or in reset: syncs at their inactive level.
  function automatic pix_out_t idle_outputs(input bit hs_pol, input bit vs_pol);
    pix_out_t o;
    o.hsync       = ~hs_pol;
    o.vsync       = ~vs_pol;
    o.de          = 1'b0;
    o.mode        = CTRL;
    o.ctl         = 4'b0000;
    o.frame_start = 1'b0;
    o.running     = 1'b0;
    return o;
  endfunction

endpackage

// File: rtl/hdmi_raster_counter.sv
// Pixel/line raster counter with hold and clear. Exposes the next-cycle
// position so the owner can register decode outputs aligned with the counters.
module hdmi_raster_counter
  import hdmi_pkg::*;
#(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic                pixclk,
  input  logic                reset,
  input  logic                clear,
  input  logic                hold,
  output logic [HCOUNT_W-1:0] hcount,
  output logic [VCOUNT_W-1:0] vcount,
  output logic [HCOUNT_W-1:0] next_hcount,
  output logic [VCOUNT_W-1:0] next_vcount,
  output logic                frame_end
);

  localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(H_TOTAL - 1);
  localparam logic [VCOUNT_W-1:0] V_LAST = VCOUNT_W'(V_TOTAL - 1);
  localparam logic [HCOUNT_W-1:0] H_ONE  = HCOUNT_W'(1);
  localparam logic [VCOUNT_W-1:0] V_ONE  = VCOUNT_W'(1);

  logic line_end;

  assign line_end  = (hcount == H_LAST);
  assign frame_end = line_end && (vcount == V_LAST);

  // NOTE: every output gets a default before any branch, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    next_hcount = hcount;
    next_vcount = vcount;
    if (clear) begin
      next_hcount = '0;
      next_vcount = '0;
    end else if (!hold) begin
      if (line_end) begin
        next_hcount = '0;
        next_vcount = (vcount == V_LAST) ? '0 : vcount + V_ONE;
      end else begin
        next_hcount = hcount + H_ONE;
      end
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values and
  // the result does not depend on block evaluation order.
  always_ff @(posedge pixclk) begin
    if (!reset) begin
      hcount <= '0;
      vcount <= '0;
    end else begin
      hcount <= next_hcount;
      vcount <= next_vcount;
    end
  end

endmodule

// File: rtl/hdmi_period_scheduler.sv
// HDMI TMDS period scheduler: raster timing, sync generation and per-pixel
// encoder period selection with clean start and frame-completing stop.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic                pixclk,
  input  logic                reset,
  input  logic                en,
  output logic [HCOUNT_W-1:0] hcount,
  output logic [VCOUNT_W-1:0] vcount,
  output logic                hsync,
  output logic                vsync,
  output logic                de,
  output logic [1:0]          enc_mode,
  output logic [3:0]          ctl,
  output logic                frame_start,
  output logic                running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_FP + H_SYNC + H_BP < PREAMBLE_LEN + GUARD_LEN + 2) begin : g_blank_too_short
    $error("horizontal blanking too short for preamble and guard band");
  end
  if (H_TOTAL > 2 ** HCOUNT_W || V_TOTAL > 2 ** VCOUNT_W) begin : g_raster_too_large
    $error("raster does not fit the counter widths");
  end

  localparam logic [HCOUNT_W-1:0] H_ACT       = HCOUNT_W'(H_ACTIVE);
  localparam logic [HCOUNT_W-1:0] HS_START    = HCOUNT_W'(H_ACTIVE + H_FP);
  localparam logic [HCOUNT_W-1:0] HS_END      = HCOUNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HCOUNT_W-1:0] PRE_START   = HCOUNT_W'(H_TOTAL - PREAMBLE_LEN - GUARD_LEN);
  localparam logic [HCOUNT_W-1:0] GUARD_START = HCOUNT_W'(H_TOTAL - GUARD_LEN);
  localparam logic [VCOUNT_W-1:0] V_ACT       = VCOUNT_W'(V_ACTIVE);
  localparam logic [VCOUNT_W-1:0] VS_START    = VCOUNT_W'(V_ACTIVE + V_FP);
  localparam logic [VCOUNT_W-1:0] VS_END      = VCOUNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VCOUNT_W-1:0] V_LAST      = VCOUNT_W'(V_TOTAL - 1);
  localparam logic [VCOUNT_W-1:0] V_ONE       = VCOUNT_W'(1);

  localparam pix_out_t IDLE_OUT = idle_outputs(HS_POL, VS_POL);

  sched_state_t          state;
  pix_out_t              out_q;
  pix_out_t              act;
  logic [HCOUNT_W-1:0]   next_h;
  logic [VCOUNT_W-1:0]   next_v;
  logic                  frame_end;
  logic                  stop_now;
  logic                  next_line_active;
  logic                  island_ok;

  // Counters stay at 0 in IDLE; a stop at the frame's last pixel clears them.
  assign stop_now = (state != IDLE) && frame_end && !en;

  hdmi_raster_counter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_raster (
    .pixclk      (pixclk),
    .reset       (reset),
    .clear       (stop_now),
    .hold        (state == IDLE),
    .hcount      (hcount),
    .vcount      (vcount),
    .next_hcount (next_h),
    .next_vcount (next_v),
    .frame_end   (frame_end)
  );

  // Decode for the position the counters will show next cycle. The last line
  // of a draining frame drops preamble/guard since no line 0 follows it.
  always_comb begin
    act              = IDLE_OUT;
    next_line_active = (next_v == V_LAST) || ((next_v + V_ONE) < V_ACT);
    island_ok        = next_line_active && !(!en && (next_v == V_LAST));

    act.running      = 1'b1;
    act.de           = (next_h < H_ACT) && (next_v < V_ACT);
    act.hsync        = (next_h >= HS_START && next_h < HS_END) ? HS_POL : ~HS_POL;
    act.vsync        = (next_v >= VS_START && next_v < VS_END) ? VS_POL : ~VS_POL;
    act.frame_start  = (next_h == '0) && (next_v == '0);

    if (act.de)                                act.mode = VIDEO;
    else if (island_ok && next_h >= GUARD_START) act.mode = GUARD;
    else if (island_ok && next_h >= PRE_START)   act.mode = PREAMBLE;
    else                                       act.mode = CTRL;

    act.ctl = (act.mode == PREAMBLE) ? CTL_VIDEO_PREAMBLE : 4'b0000;
  end

  always_ff @(posedge pixclk) begin
    if (!reset) begin
      state <= IDLE;
      out_q <= IDLE_OUT;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state <= RUN;
            out_q <= act;
          end else begin
            out_q <= IDLE_OUT;
          end
        end
        RUN, DRAIN: begin
          if (stop_now) begin
            state <= IDLE;
            out_q <= IDLE_OUT;
          end else begin
            state <= en ? RUN : DRAIN;
            out_q <= act;
          end
        end
        default: begin
          state <= IDLE;
          out_q <= IDLE_OUT;
        end
      endcase
    end
  end

  assign hsync       = out_q.hsync;
  assign vsync       = out_q.vsync;
  assign de          = out_q.de;
  assign enc_mode    = out_q.mode;
  assign ctl         = out_q.ctl;
  assign frame_start = out_q.frame_start;
  assign running     = out_q.running;

endmodule

// File: doc/hdmi_period_scheduler.md
Name: hdmi_period_scheduler

Overview:
- Sequences the HDMI TMDS datapath per pixel clock: raster counters, sync generation and per-pixel encoder period selection (control / video preamble / video guard band / video data).
- Sits between the pixel source and the three TMDS channel encoders inside top, driving their mode and CTL inputs.
- Supports clean start/stop: stopping always completes the current frame before returning to idle.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level

Ports:
- pixclk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- en  in  1  run request; level-sensitive
- hcount  out  12  pixel index in line, 0..H_TOTAL-1
- vcount  out  11  line index in frame, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- de  out  1  video data enable
- enc_mode  out  2  0=CTRL, 1=PREAMBLE, 2=GUARD, 3=VIDEO
- ctl  out  4  CTL3..CTL0 to encoders 1/2
- frame_start  out  1  one-cycle pulse at (0,0)
- running  out  1  high in RUN or DRAIN

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL similarly. Elaboration error if H_FP+H_SYNC+H_BP < 12.
- Reset (reset==0 at edge): state IDLE, hcount=0, vcount=0, hsync=~HS_POL, vsync=~VS_POL, de=0, enc_mode=CTRL, ctl=0, frame_start=0, running=0. Dominates en.
- All outputs registered and mutually aligned: each output in a cycle describes the (hcount,vcount) shown in that same cycle.
- States:
  - IDLE: counters held at 0, outputs at reset values. If en=1, next cycle enters RUN at (0,0) with frame_start=1.
  - RUN: hcount increments and wraps at H_TOTAL-1 -> 0; on wrap vcount increments and wraps at V_TOTAL-1 -> 0. frame_start=1 on every cycle at (0,0). If en=0, go to DRAIN (counting continues).
  - DRAIN: behaves as RUN. If en returns to 1, go back to RUN. At (H_TOTAL-1, V_TOTAL-1) go to IDLE; the next cycle shows IDLE values with no frame_start.
- Decode:
  - de=1 iff hcount<H_ACTIVE and vcount<V_ACTIVE.
  - hsync active iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, on all lines.
  - vsync active iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, whole lines.
  - Next line is active iff (vcount+1) mod V_TOTAL < V_ACTIVE.
  - enc_mode:
    - VIDEO when de=1.
    - PREAMBLE for hcount in [H_TOTAL-10, H_TOTAL-3] when the next line is active.
    - GUARD for hcount in [H_TOTAL-2, H_TOTAL-1] when the next line is active.
    - CTRL otherwise.
  - ctl=4'b0001 during PREAMBLE, else 0.
  - In DRAIN, the last line of the frame does not emit preamble/guard if the transition goes to IDLE; it does emit them if en has returned to 1.

Decomposition:
- Package hdmi_pkg: enc_mode_t enum (CTRL, PREAMBLE, GUARD, VIDEO), CTL_VIDEO_PREAMBLE=4'b0001, PREAMBLE_LEN=8, GUARD_LEN=2, sched_state_t (IDLE, RUN, DRAIN).
- One sub-module is natural: hdmi_raster_counter (hcount/vcount with wrap flags, hold/clear inputs).
- Decode and FSM stay in the top of this block.

Test Plan:
All scenarios use H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=10 (H_TOTAL=22) and V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7).
- Reset then en=1 -> first RUN cycle (0,0) with frame_start=1, de=1, enc_mode=VIDEO. frame_start repeats every 154 cycles.
- Line 0 sweep -> de for hcount 0..7; hsync low for hcount 10..11; PREAMBLE with ctl=0001 for 12..19; GUARD for 20..21.
- Lines 3,4,5 -> no PREAMBLE/GUARD. Line 6 -> PREAMBLE 12..19, GUARD 20..21. vsync low on line 5 only.
- en=0 at (3,2) -> running stays 1 until (21,6) with no preamble/guard on line 6; next cycle IDLE, counters 0, running=0.
- en drops at (3,2) and returns at (0,5) -> no IDLE; line 6 emits preamble/guard; frame_start at the next (0,0).
- reset=0 at (5,1) mid-frame -> next cycle all outputs at reset values. Releasing with en=1 restarts at (0,0) with frame_start.
